// File: rtl/cod25_display_scan.sv
// Scan controller for a bank of seven-segment digits fed from 2-of-5 coded inputs.
// Lights one digit per slot with an optional all-off blanking gap between slots.
module cod25_display_scan #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] code_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [NUM_DIGITS-1:0]   err_flags,
    output logic                    frame_tick
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHOW  = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    localparam int unsigned MAX_CNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, idx_next;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [5*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    tick_q, tick_d;

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'b11000: s = 7'h3F;
            5'b00011: s = 7'h06;
            5'b00101: s = 7'h5B;
            5'b00110: s = 7'h4F;
            5'b01001: s = 7'h66;
            5'b01010: s = 7'h6D;
            5'b01100: s = 7'h7D;
            5'b10001: s = 7'h07;
            5'b10010: s = 7'h7F;
            5'b10100: s = 7'h6F;
            default:  s = 7'h40;
        endcase
        return s;
    endfunction

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        shadow_d = load ? code_in : shadow_q;
        err_d    = err_q;
        if (load) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                err_d[i] = ($countones(code_in[5*i +: 5]) != 2);
            end
        end

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                        end else begin
                            idx_d  = idx_next;
                            tick_d = (idx_next == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        idx_d   = idx_next;
                        tick_d  = (idx_next == '0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Decode from the next shadow so a load during SHOW is visible one cycle later.
        seg_d = '0;
        dig_d = '0;
        if (state_d == SHOW) begin
            dig_d[idx_d] = 1'b1;
            seg_d        = decode(shadow_d[5*idx_d +: 5]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= '0;
            seg_q    <= '0;
            dig_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            tick_q   <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_q;
    assign err_flags  = err_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/cod25_display_scan.md
Name: cod25_display_scan

Overview:
Time-multiplexed scan controller for a bank of seven-segment digits driven from 2-of-5 coded inputs. Captures NUM_DIGITS 5-bit 2-of-5 codes on a load strobe, validates each code and sequences one digit at a time onto a shared segment bus with one-hot digit select. It inserts an all-off blanking gap between digits to prevent ghosting. It sits between the 2-of-5 input logic and the physical display drivers.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (>=1).
PRESCALE, 50000, clock cycles each digit is lit per slot (>=1).
BLANK_CYCLES, 500, all-off cycles between slots (0 = no blanking state).

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; low forces display dark.
load  input  1  single-cycle strobe: capture code_in into shadow registers.
code_in  input  5*NUM_DIGITS  digit i = code_in[5i+4:5i]; bit order E1..E5 = [5i+4]..[5i].
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
dig_sel  output  NUM_DIGITS  one-hot digit enable, active-high, registered.
err_flags  output  NUM_DIGITS  bit i = shadow digit i is not a valid 2-of-5 code.
frame_tick  output  1  one-cycle pulse at the start of each scan frame.

Behaviour:
- Reset (async, rst_n low): state IDLE, idx=0, counter=0, shadow=0, seg=0, dig_sel=0, err_flags=0, frame_tick=0. Reset mid-scan aborts immediately with no partial-slot completion.
- Code table (E1..E5 weights 7,4,2,1,0): 11000=0, 00011=1, 00101=2, 00110=3, 01001=4, 01010=5, 01100=6, 10001=7, 10010=8, 10100=9.
- Segment values (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any code with popcount != 2 shows dash = 40.
- load: the shadow register and err_flags are updated on the same edge, with err_flags[i] = (popcount(code_in digit i) != 2). Capture occurs regardless of en or state. If load is high in a SHOW cycle, seg reflects the new shadow value on the following cycle.
- FSM states:
  - IDLE: seg=0, dig_sel=0. With en=1, the next edge moves to SHOW with idx=0, counter=0, dig_sel=1<<0, seg=decode(shadow[0]) and frame_tick=1 for that one cycle.
  - SHOW: dig_sel=1<<idx, seg=decode(shadow[idx]). counter increments each cycle. At counter==PRESCALE-1:
    - If BLANK_CYCLES>0: go to BLANK with counter=0; seg and dig_sel both 0 on the next cycle.
    - Otherwise: idx advances and SHOW continues with counter=0.
  - BLANK: seg=0, dig_sel=0. At counter==BLANK_CYCLES-1, go to SHOW with idx advanced and counter=0.
- idx advance: idx+1, wrapping from NUM_DIGITS-1 to 0. Every entry into SHOW with idx=0 (wrap or start from IDLE) asserts frame_tick for exactly that first cycle.
- Slot length: PRESCALE+BLANK_CYCLES cycles. Frame length: NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
- en low in any state: next edge goes to IDLE with seg=0, dig_sel=0, idx=0, counter=0, frame_tick=0. Shadow and err_flags are retained. Re-enabling restarts the scan at digit 0.
- dig_sel is always zero or one-hot, never multi-hot, and is never non-zero in BLANK or IDLE.
- NUM_DIGITS=1: idx stays 0 and frame_tick pulses at every SHOW entry.

Test Plan:
Use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1 unless stated.
1. Reset, then load code_in = {10100,01001,00011,11000} (digit3..0), en=1 -> err_flags=0000. Sequence from the first SHOW cycle: dig_sel=0001/seg=3F for 4 cycles, then 1 cycle of 0/0, then 0010/06, then 0100/66, then 1000/6F. frame_tick high on the first cycle and again 20 cycles later.
2. Load digit1=00111 and digit2=00000 with other digits valid -> err_flags=0110; both digits show seg=40 in their slots.
3. Load new values while digit 2 is lit -> seg for digit 2 changes on the next cycle and dig_sel is unchanged. Slot timing is unaffected.
4. Drop en for 1 cycle during digit 3 -> next cycle seg=0 and dig_sel=0. Re-raise en -> next SHOW is digit 0 with frame_tick=1. err_flags are unchanged.
5. Assert rst_n low asynchronously mid-slot (between clock edges) -> seg, dig_sel, err_flags and frame_tick go to 0 immediately. After release with en=1, digit 0 shows 40 (shadow=00000).
6. With BLANK_CYCLES=0 -> no dark cycles and a frame length of 16 cycles. Check every cycle that dig_sel is one-hot and the frame_tick period is 16.
